// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared types and constants for the button debouncer
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } btn_state_t;

    localparam logic BTN_RELEASED = 1'b1;

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    function automatic int cnt_width(input int debounce_cycles);
        return (debounce_cycles <= 2) ? 1 : $clog2(debounce_cycles);
    endfunction

endpackage

// File: rtl/button_debouncer_cell.sv
// rtl/button_debouncer_cell.sv - one button: synchroniser, debounce FSM, counter, event pulses
module debounce_cell
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_n,
    output logic btn_clean_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic pending
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             clean_nxt, press_nxt, release_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= BTN_RELEASED;
            sync2         <= BTN_RELEASED;
            state         <= RELEASED;
            cnt           <= '0;
            btn_clean_n   <= BTN_RELEASED;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= btn_raw_n;
            sync2         <= sync1;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            btn_clean_n   <= clean_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // Pending states count consecutive agreeing samples; any disagreement reverts.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        clean_nxt   = btn_clean_n;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (!sync2) begin
                    state_nxt = PRESS_PENDING;
                    cnt_nxt   = '0;
                end
            end
            PRESS_PENDING: begin
                if (sync2) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    clean_nxt = 1'b0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (sync2) begin
                    state_nxt = RELEASE_PENDING;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_PENDING: begin
                if (!sync2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = RELEASED;
                    cnt_nxt     = '0;
                    clean_nxt   = 1'b1;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign pending = (state == PRESS_PENDING) || (state == RELEASE_PENDING);

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounces N_BTN active-low buttons and flags when all are settled
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw_n,
    output logic [N_BTN-1:0] btn_clean_n,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic             stable
);

    logic [N_BTN-1:0] pending;

    for (genvar i = 0; i < N_BTN; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_raw_n    (btn_raw_n[i]),
            .btn_clean_n  (btn_clean_n[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .pending      (pending[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
        end else begin
            stable <= ~|pending;
        end
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Front-end conditioning stage for the board push-buttons.
- Takes raw, asynchronous, bouncing active-low button pins.
- Feeds clean, synchronous, still active-low levels to the combinational decode logic downstream (the A/B/C/D inputs of the button-to-LED logic).
- Also provides one-cycle press/release event pulses and an all-settled flag for later sequential consumers.

Parameters:
- N_BTN, 4, number of independent buttons debounced.
- DEBOUNCE_CYCLES, 12000, consecutive stable clk samples required to accept a level change (1 ms at 12 MHz); legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-button counter; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset. Assertion is asynchronous. Deassertion is assumed synchronised externally.
- btn_raw_n  in  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to clk.
- btn_clean_n  out  N_BTN  debounced level, active-low, registered.
- press_pulse  out  N_BTN  one-cycle high when the corresponding btn_clean_n falls 1->0.
- release_pulse  out  N_BTN  one-cycle high when the corresponding btn_clean_n rises 0->1.
- stable  out  1  high when no button is in a pending state; registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync flops = all 1; btn_clean_n = all 1.
  - press_pulse = 0; release_pulse = 0; stable = 1.
  - all FSMs = RELEASED; all counters = 0.
  - Asserting reset mid-debounce discards pending changes. There is no pulse on reset entry or exit.
- Synchroniser: 2-flop chain per bit (sync1 <= btn_raw_n, sync2 <= sync1). The FSM sees only sync2.
- Per-button FSM, states RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING:
  - RELEASED: if sync2=0, go to PRESS_PENDING with cnt<=0; otherwise stay.
  - PRESS_PENDING:
    - if sync2=1, go to RELEASED with cnt<=0 (glitch rejected, no pulse);
    - else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED with cnt<=0, clean<=0, press_pulse<=1;
    - else cnt<=cnt+1.
  - PRESSED: if sync2=1, go to RELEASE_PENDING with cnt<=0.
  - RELEASE_PENDING: mirror of PRESS_PENDING with levels inverted. Completion sets clean<=1 and release_pulse<=1. A revert returns to PRESSED.
- Latency: a raw edge first sampled low at clk edge e, and held low through edge e+DEBOUNCE_CYCLES, produces btn_clean_n=0 and press_pulse=1 after edge e+DEBOUNCE_CYCLES+2. Both are registered and change on the same edge.
- Glitch rule: a raw level held for DEBOUNCE_CYCLES consecutive samples or fewer causes no output change and no pulse.
- Pulses are exactly one cycle wide. press_pulse and release_pulse are never both high for the same bit.
- Buttons are fully independent. Simultaneous changes on several bits produce pulses on the same cycle.
- stable is registered: it is 0 the cycle after any FSM enters a *_PENDING state, and 1 the cycle after all FSMs are in RELEASED or PRESSED.
- Counter never wraps: it saturates logically because the state exits at DEBOUNCE_CYCLES-1.
- No combinational path from btn_raw_n to any output.

Decomposition:
- Package button_debouncer_pkg:
  - typedef enum of the 4 FSM states (2-bit encoding);
  - localparam/function for CNT_W derivation;
  - reset level constant BTN_RELEASED = 1'b1.
- Sub-module debounce_cell (one button: synchroniser, FSM, counter, pulse regs) with parameter DEBOUNCE_CYCLES.
- Top instantiates N_BTN cells via generate and ORs the per-cell pending flags into stable.

Test Plan (DEBOUNCE_CYCLES=4, N_BTN=4):
- Reset while btn_raw_n=4'b0000 -> all outputs at reset values. After release of rst_n and raw held 0: btn_clean_n=4'b0000 and press_pulse=4'b1111 for exactly one cycle, 6 edges after the first sampling edge.
- Bit0 driven low for 3 cycles then high, others high -> btn_clean_n stays 4'b1111, no pulses, stable drops to 0 then returns to 1.
- Bit2 pressed (held low 20 cycles) then released (held high 20 cycles) -> btn_clean_n[2] falls at edge 6 and rises 6 edges after release is first sampled. One press_pulse[2] and one release_pulse[2] occur; stable=1 at end.
- Bounce pattern on bit1, low/high alternating every cycle for 10 cycles then steady low -> exactly one press_pulse[1], 6 edges after steady low begins.
- Bit3 in PRESS_PENDING (raw low 3 cycles) with rst_n asserted asynchronously mid-clock -> outputs clear immediately without waiting for clk. After rst_n release with raw high, no pulse ever appears.
- Bits 0 and 3 pressed on the same cycle -> press_pulse=4'b1001 in a single cycle; btn_clean_n=4'b0110.
